// File: rtl/coef_rotator_pkg.sv
// coef_pkg: shared states, mode/direction encodings and count-width helper for coef_rotator
package coef_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    typedef enum logic [0:0] {IDLE = ST_IDLE, ACTIVE = ST_ACTIVE} state_t;
    localparam logic MODE_CYCLIC = 1'b0;
    localparam logic MODE_NEGACYCLIC = 1'b1;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/coef_rotator_if.sv
// coef_rotator_if: load handshake, step control and lane outputs of the coefficient rotator
interface coef_rotator_if #(
    parameter int N = 4,
    parameter int W = 2
);
    import coef_pkg::*;
    logic load_valid;
    logic load_ready;
    logic [N*W-1:0] load_data;
    logic load_mode;
    logic step_en;
    logic dir;
    logic abort;
    logic [N*W-1:0] coef_flat;
    logic coef_valid;
    logic [cnt_w(N)-1:0] step_cnt;
    logic done;
    modport master (
        output load_valid, load_data, load_mode, step_en, dir, abort,
        input load_ready, coef_flat, coef_valid, step_cnt, done
    );
    modport slave (
        input load_valid, load_data, load_mode, step_en, dir, abort,
        output load_ready, coef_flat, coef_valid, step_cnt, done
    );
endinterface

// File: rtl/coef_rotator_neg_mod.sv
// coef_neg_mod: two's-complement negation mod 2^W for the wrap lane
module coef_neg_mod #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = ~a + W'(1);
endmodule

// File: rtl/coef_rotator.sv
// coef_rotator: N-lane register multiplying the held polynomial by x or x^-1, cyclic or negacyclic
module coef_rotator
    import coef_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic clk,
    input  logic reset,
    coef_rotator_if.slave bus
);
    localparam int CW = cnt_w(N);
    logic [N-1:0][W-1:0] c;
    logic [N-1:0][W-1:0] nxt;
    logic mode;
    logic [CW-1:0] cnt;
    logic done_q;
    state_t state;
    logic [W-1:0] neg_top;
    logic [W-1:0] neg_bot;
    coef_neg_mod #(.W(W)) u_neg_top (.a(c[N-1]), .y(neg_top));
    coef_neg_mod #(.W(W)) u_neg_bot (.a(c[0]), .y(neg_bot));
    // only the lane that wraps around the polynomial end sees the negation
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] up;
        logic [W-1:0] dn;
        assign up = (i == 0) ? (mode ? neg_top : c[N-1]) : c[(i + N - 1) % N];
        assign dn = (i == N - 1) ? (mode ? neg_bot : c[0]) : c[(i + 1) % N];
        assign nxt[i] = (bus.dir == DIR_DOWN) ? dn : up;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c <= '0;
            mode <= MODE_CYCLIC;
            cnt <= '0;
            done_q <= 1'b0;
            state <= IDLE;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.load_valid) begin
                    c <= bus.load_data;
                    mode <= bus.load_mode;
                    cnt <= '0;
                    state <= ACTIVE;
                end
            end else if (bus.abort) begin
                state <= IDLE;
            end else if (bus.step_en) begin
                c <= nxt;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    state <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end
    assign bus.load_ready = (state == IDLE);
    assign bus.coef_valid = (state == ACTIVE);
    assign bus.coef_flat = c;
    assign bus.step_cnt = cnt;
    assign bus.done = done_q;
endmodule

// File: tb/tb_coef_rotator.sv
// tb_coef_rotator: directed vector table, corner sequences and a randomized polynomial reference model
module tb_coef_rotator;
    localparam int N = 4;
    localparam int W = 2;
    localparam int MASK = (1 << W) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    coef_rotator_if #(.N(N), .W(W)) bus ();
    coef_rotator #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic mode;
        logic dir;
        int nsteps;
        logic [7:0] exp_coef;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.load_mode = 1'b0;
        bus.step_en = 1'b0;
        bus.dir = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] d, input logic m);
        bus.load_valid = 1'b1;
        bus.load_data = d;
        bus.load_mode = m;
        cyc();
        bus.load_valid = 1'b0;
        chk("load_coef", bus.coef_flat, d);
        chk("load_valid_out", bus.coef_valid, 1);
        chk("load_cnt", bus.step_cnt, 0);
    endtask

    task automatic step(input logic d);
        bus.step_en = 1'b1;
        bus.dir = d;
        cyc();
        bus.step_en = 1'b0;
    endtask

    // reference: coefficients as a polynomial, multiplied by x or x^-1 modulo x^N -/+ 1
    int mc[N];
    int mt[N];
    bit mact;
    bit mmode;
    int mcnt;
    bit mdone;

    function automatic logic [7:0] pack();
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*W +: W] = W'(mc[i]);
        return p;
    endfunction

    task automatic mul_x(input bit down);
        for (int i = 0; i < N; i++) begin
            int e;
            int v;
            e = down ? i - 1 : i + 1;
            v = mc[i];
            if (e < 0 || e >= N) v = mmode ? ((-v) & MASK) : v;
            mt[(e + N) % N] = v;
        end
        for (int i = 0; i < N; i++) mc[i] = mt[i];
    endtask

    initial begin
        logic [7:0] seq [4];
        int ns;
        vt[0] = '{8'h39, 1'b0, 1'b0, 1, 8'hE4};
        vt[1] = '{8'h39, 1'b0, 1'b0, 4, 8'h39};
        vt[2] = '{8'h79, 1'b1, 1'b0, 1, 8'hE7};
        vt[3] = '{8'h79, 1'b1, 1'b0, 4, 8'hDB};
        vt[4] = '{8'h39, 1'b0, 1'b1, 1, 8'h4E};
        vt[5] = '{8'h39, 1'b0, 1'b1, 2, 8'h93};
        vt[6] = '{8'h79, 1'b1, 1'b1, 4, 8'hDB};
        vt[7] = '{8'h80, 1'b1, 1'b0, 1, 8'h02};
        vt[8] = '{8'h00, 1'b1, 1'b1, 4, 8'h00};
        idle_in();
        bus.load_valid = 1'b1;
        bus.load_data = 8'hA5;
        #12;
        chk("rst_coef", bus.coef_flat, 0);
        chk("rst_cnt", bus.step_cnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.load_ready, 1);
        chk("rst_valid", bus.coef_valid, 0);
        idle_in();
        reset = 1'b0;
        cyc();

        for (int v = 0; v < 9; v++) begin
            do_load(vt[v].data, vt[v].mode);
            for (int k = 0; k < vt[v].nsteps; k++) begin
                step(vt[v].dir);
                chk($sformatf("vec%0d_done_s%0d", v, k), bus.done, k == N - 1);
            end
            chk($sformatf("vec%0d_coef", v), bus.coef_flat, vt[v].exp_coef);
            chk($sformatf("vec%0d_cnt", v), bus.step_cnt, vt[v].nsteps);
            chk($sformatf("vec%0d_active", v), bus.coef_valid, vt[v].nsteps < N);
            if (vt[v].nsteps < N) bus.abort = 1'b1;
            cyc();
            bus.abort = 1'b0;
            chk($sformatf("vec%0d_done_after", v), bus.done, 0);
            chk($sformatf("vec%0d_hold", v), bus.coef_flat, vt[v].exp_coef);
            chk($sformatf("vec%0d_idle", v), bus.load_ready, 1);
        end

        // asynchronous reset part-way through an operation
        do_load(8'h39, 1'b0);
        step(1'b0);
        step(1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_coef", bus.coef_flat, 0);
        chk("mid_rst_cnt", bus.step_cnt, 0);
        chk("mid_rst_ready", bus.load_ready, 1);
        chk("mid_rst_done", bus.done, 0);
        #4 reset = 1'b0;
        cyc();
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_coef", bus.coef_flat, 0);

        // step gaps with load_valid held high; reload accepted on the done cycle
        do_load(8'h39, 1'b0);
        seq = '{8'hE4, 8'h93, 8'h4E, 8'h39};
        ns = 0;
        bus.load_valid = 1'b1;
        bus.load_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            bus.step_en = (k == 0 || k == 3 || k == 5 || k == 7);
            bus.dir = 1'b0;
            if (bus.step_en) ns++;
            cyc();
            chk($sformatf("gap_coef%0d", k), bus.coef_flat, seq[ns-1]);
            chk($sformatf("gap_done%0d", k), bus.done, k == 7);
            chk($sformatf("gap_cnt%0d", k), bus.step_cnt, ns);
        end
        bus.step_en = 1'b0;
        bus.load_data = 8'h79;
        bus.load_mode = 1'b1;
        cyc();
        bus.load_valid = 1'b0;
        chk("reload_coef", bus.coef_flat, 8'h79);
        chk("reload_cnt", bus.step_cnt, 0);
        chk("reload_active", bus.coef_valid, 1);
        chk("reload_done_clr", bus.done, 0);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;

        // abort beats step_en; new load right after
        do_load(8'h39, 1'b0);
        step(1'b0);
        bus.abort = 1'b1;
        bus.step_en = 1'b1;
        cyc();
        idle_in();
        chk("abort_coef", bus.coef_flat, 8'hE4);
        chk("abort_cnt", bus.step_cnt, 1);
        chk("abort_idle", bus.load_ready, 1);
        chk("abort_done", bus.done, 0);
        step(1'b0);
        chk("idle_step_ignored", bus.coef_flat, 8'hE4);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("idle_abort_ready", bus.load_ready, 1);
        chk("idle_abort_cnt", bus.step_cnt, 1);
        do_load(8'h79, 1'b1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;

        // randomized traffic against the polynomial model
        for (int i = 0; i < N; i++) mc[i] = 0;
        for (int i = 0; i < N; i++) mc[i] = (8'h79 >> (i * W)) & MASK;
        mact = 0;
        mmode = 1;
        mcnt = 0;
        for (int it = 0; it < 600; it++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data = 8'($urandom);
            bus.load_mode = 1'($urandom_range(0, 1));
            bus.step_en = ($urandom_range(0, 9) < 7);
            bus.dir = 1'($urandom_range(0, 1));
            bus.abort = ($urandom_range(0, 19) == 0);
            mdone = 0;
            if (!mact) begin
                if (bus.load_valid) begin
                    for (int i = 0; i < N; i++) mc[i] = (bus.load_data >> (i * W)) & MASK;
                    mmode = bus.load_mode;
                    mcnt = 0;
                    mact = 1;
                end
            end else if (bus.abort) begin
                mact = 0;
            end else if (bus.step_en) begin
                mul_x(bus.dir);
                mcnt++;
                if (mcnt == N) begin
                    mact = 0;
                    mdone = 1;
                end
            end
            cyc();
            chk("rnd_coef", bus.coef_flat, pack());
            chk("rnd_cnt", bus.step_cnt, mcnt);
            chk("rnd_done", bus.done, mdone);
            chk("rnd_valid", bus.coef_valid, mact);
            chk("rnd_ready", bus.load_ready, !mact);
        end
        idle_in();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
